// File: rtl/proc_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
//   Definitions shared by the control unit, the bus MUX and the ALU:
//   - opcode values
//   - control-step encoding T0..T3
//   - bus-select bit positions
//   - ALU operation codes
// ---------------------------------------------------------------------------
package proc_pkg;

  // Opcodes, taken from instruction bits [8:6]
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  // Control steps
  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Bus-select bit positions.
  // R0..R7 occupy bits [8:1]; register Ri sits at bit SEL_DIN-1-i.
  localparam int SEL_DIN = 9;
  localparam int SEL_G   = 0;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  // Map an ALU opcode to its ALU operation.
  // Non-ALU opcodes map to ALU_ADD, which is the idle value of AluOp.
  function automatic logic [1:0] alu_op_of(input logic [2:0] op);
    case (op)
      OP_SUB:  alu_op_of = ALU_SUB;
      OP_AND:  alu_op_of = ALU_AND;
      default: alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_control_fsm_if.sv
// ---------------------------------------------------------------------------
// proc_control_fsm_if
//   Bus-select / register-enable interface between the control unit
//   (master) and the bus MUX / register file (slave).
//
//   Run    : start request, sampled only in T0
//   DIN    : instruction / immediate source
//   BusSel : one-hot bus-select word
//   Rin    : register load enables
//   Ain    : load A from the bus
//   Gin    : load G from the ALU
//   AluOp  : ALU operation
//   IRin   : IR load strobe
//   Done   : end-of-instruction pulse
// ---------------------------------------------------------------------------
interface proc_control_fsm_if #(
  parameter int DATA_W = 16,
  parameter int N_REGS = 8,
  parameter int SEL_W  = N_REGS + 2
);
  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic [SEL_W-1:0]  BusSel;
  logic [N_REGS-1:0] Rin;
  logic              Ain;
  logic              Gin;
  logic [1:0]        AluOp;
  logic              IRin;
  logic              Done;

  modport master (
    input  Run, DIN,
    output BusSel, Rin, Ain, Gin, AluOp, IRin, Done
  );

  modport slave (
    output Run, DIN,
    input  BusSel, Rin, Ain, Gin, AluOp, IRin, Done
  );
endinterface

// File: rtl/proc_control_fsm_onehot_reg_dec.sv
// ---------------------------------------------------------------------------
// onehot_reg_dec
//   Converts a register index into an N-bit one-hot word (bit idx set).
//
//   idx : register index
//   oh  : one-hot decode of idx
// ---------------------------------------------------------------------------
module onehot_reg_dec #(
  parameter int N_REGS = 8,
  parameter int IDX_W  = $clog2(N_REGS)
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [N_REGS-1:0] oh
);
  assign oh = N_REGS'(1) << idx;
endmodule

// File: rtl/proc_control_fsm.sv
// ---------------------------------------------------------------------------
// proc_control_fsm
//   Control unit for the 16-bit register-bus datapath.
//   It fetches a 9-bit instruction (III XXX YYY) from DIN in T0, then
//   sequences it over T1..T3. Outputs are decoded combinationally from the
//   current step and the IR.
//
//   Clock  : rising-edge clock
//   Resetn : synchronous, active-low reset. While low, all outputs are
//            forced to the idle value.
//   bus    : master side of proc_control_fsm_if
//            (Run, DIN in; BusSel, Rin, Ain, Gin, AluOp, IRin, Done out)
// ---------------------------------------------------------------------------
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9,
  parameter int N_REGS = 8,
  parameter int SEL_W  = N_REGS + 2
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  proc_control_fsm_if.master   bus
);

  localparam int RIDX_W = $clog2(N_REGS);

  state_t            state;
  state_t            state_nxt;
  logic [IR_W-1:0]   ir;
  logic [2:0]        opcode;
  logic [RIDX_W-1:0] rx;
  logic [RIDX_W-1:0] ry;
  logic [N_REGS-1:0] dec_x;
  logic [N_REGS-1:0] dec_y;
  logic              ir_load;

  // Only DIN[IR_W-1:0] carries the instruction; the upper bits
  // reach the datapath through the bus, not through the control unit.
  logic unused_din;
  assign unused_din = ^bus.DIN[DATA_W-1:IR_W];

  assign opcode = ir[IR_W-1 -: 3];
  assign rx     = ir[2*RIDX_W-1 -: RIDX_W];
  assign ry     = ir[RIDX_W-1:0];

  // Rx drives both the Rin write enable and the A-load bus select.
  // Ry drives the source-operand bus select.
  onehot_reg_dec #(.N_REGS(N_REGS), .IDX_W(RIDX_W)) u_dec_x (
    .idx (rx),
    .oh  (dec_x)
  );

  onehot_reg_dec #(.N_REGS(N_REGS), .IDX_W(RIDX_W)) u_dec_y (
    .idx (ry),
    .oh  (dec_y)
  );

  // Place a register one-hot into the bus-select field.
  // Ri maps to bit SEL_DIN-1-i, so R0 sits just below DIN.
  function automatic logic [SEL_W-1:0] reg_sel(input logic [N_REGS-1:0] oh);
    reg_sel = '0;
    for (int i = 0; i < N_REGS; i++) begin
      reg_sel[SEL_DIN-1-i] = oh[i];
    end
  endfunction

  function automatic logic [SEL_W-1:0] fixed_sel(input int bitpos);
    fixed_sel = '0;
    fixed_sel[bitpos] = 1'b1;
  endfunction

  assign ir_load = (state == T0) && bus.Run;

  // State and IR registers
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) begin
        ir <= bus.DIN[IR_W-1:0];
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt  = state;
    bus.BusSel = fixed_sel(SEL_DIN);
    bus.Rin    = '0;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.AluOp  = ALU_ADD;
    bus.IRin   = 1'b0;
    bus.Done   = 1'b0;

    case (state)
      T0: begin
        if (bus.Run) begin
          bus.IRin  = 1'b1;
          state_nxt = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            bus.BusSel = reg_sel(dec_y);
            bus.Rin    = dec_x;
            bus.Done   = 1'b1;
            state_nxt  = T0;
          end
          OP_MVI: begin
            // The immediate value is carried on DIN during this cycle.
            bus.Rin   = dec_x;
            bus.Done  = 1'b1;
            state_nxt = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            bus.BusSel = reg_sel(dec_x);
            bus.Ain    = 1'b1;
            state_nxt  = T2;
          end
          default: begin
            // Illegal opcode: retire with no register side effects.
            bus.Done  = 1'b1;
            state_nxt = T0;
          end
        endcase
      end
      T2: begin
        bus.BusSel = reg_sel(dec_y);
        bus.Gin    = 1'b1;
        bus.AluOp  = alu_op_of(opcode);
        state_nxt  = T3;
      end
      T3: begin
        bus.BusSel = fixed_sel(SEL_G);
        bus.Rin    = dec_x;
        bus.Done   = 1'b1;
        state_nxt  = T0;
      end
      default: state_nxt = T0;
    endcase

    // Reset overrides the decode immediately, so an aborted instruction
    // cannot leak an enable during the reset cycles.
    if (!Resetn) begin
      bus.BusSel = fixed_sel(SEL_DIN);
      bus.Rin    = '0;
      bus.Ain    = 1'b0;
      bus.Gin    = 1'b0;
      bus.AluOp  = ALU_ADD;
      bus.IRin   = 1'b0;
      bus.Done   = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_proc_control_fsm
//   Directed and random instruction streams for proc_control_fsm.
//   Each instruction is expanded into its expected per-cycle bus activity
//   from the instruction-set rules, then compared with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_proc_control_fsm;

  localparam int DATA_W = 16;
  localparam int IR_W   = 9;
  localparam int N_REGS = 8;
  localparam int SEL_W  = 10;

  typedef struct packed {
    logic [9:0] sel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic [1:0] aluop;
    logic       irin;
    logic       done;
  } exp_t;

  logic Clock  = 1'b0;
  logic Resetn = 1'b0;

  int total = 0;
  int bad   = 0;
  int cycnt = 0;
  int last_done_cyc = -100;
  int done_gap = 0;

  proc_control_fsm_if #(.DATA_W(DATA_W), .N_REGS(N_REGS), .SEL_W(SEL_W)) bif ();

  proc_control_fsm #(
    .DATA_W (DATA_W),
    .IR_W   (IR_W),
    .N_REGS (N_REGS),
    .SEL_W  (SEL_W)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bif.master)
  );

  always #5 Clock = ~Clock;

  // Bus-select bit positions: DIN=9, Ri=8-i, G=0
  function automatic exp_t mk(input int selbit, input logic [7:0] rin,
                              input logic ain, input logic gin,
                              input logic [1:0] aluop, input logic irin,
                              input logic done);
    exp_t e;
    e.sel   = 10'd1 << selbit;
    e.rin   = rin;
    e.ain   = ain;
    e.gin   = gin;
    e.aluop = aluop;
    e.irin  = irin;
    e.done  = done;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    return mk(9, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle and check the outputs mid-cycle.
  // Entry and exit are 1 time unit after a rising edge.
  task automatic cyc(input logic run, input logic [15:0] din, input exp_t e, input string tag);
    bif.Run = run;
    bif.DIN = din;
    #2;
    chk({tag, ".sel"},  16'(bif.BusSel), 16'(e.sel));
    chk({tag, ".rin"},  16'(bif.Rin),    16'(e.rin));
    chk({tag, ".ctl"},  16'({bif.Ain, bif.Gin, bif.AluOp, bif.IRin, bif.Done}),
                        16'({e.ain, e.gin, e.aluop, e.irin, e.done}));
    chk({tag, ".onehot"}, 16'({$onehot(bif.BusSel), $onehot0(bif.Rin)}), 16'b11);
    if (bif.Done === 1'b1) begin
      done_gap      = cycnt - last_done_cyc;
      last_done_cyc = cycnt;
    end
    @(posedge Clock);
    #1;
    cycnt++;
  endtask

  // Issue one instruction with Run=1 in T0, then run its remaining steps.
  // Run is random after fetch, because it must be ignored outside T0.
  // DIN carries imm in T1 and random values otherwise.
  task automatic run_instr(input logic [8:0] instr, input logic [15:0] imm, input string tag);
    exp_t q[$];
    int   op;
    int   x;
    int   y;
    op = int'(instr[8:6]);
    x  = int'(instr[5:3]);
    y  = int'(instr[2:0]);
    q.push_back(mk(9, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
    if (op == 0) begin
      q.push_back(mk(8 - y, 8'd1 << x, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    end else if (op == 1) begin
      q.push_back(mk(9, 8'd1 << x, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    end else if (op <= 4) begin
      q.push_back(mk(8 - x, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
      q.push_back(mk(8 - y, 8'h00, 1'b0, 1'b1, 2'(op - 2), 1'b0, 1'b0));
      q.push_back(mk(0, 8'd1 << x, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    end else begin
      q.push_back(mk(9, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
    end
    for (int k = 0; k < q.size(); k++) begin
      if (k == 0)      cyc(1'b1, {7'($urandom), instr}, q[k], tag);
      else if (k == 1) cyc(1'($urandom), imm, q[k], tag);
      else             cyc(1'($urandom), 16'($urandom), q[k], tag);
    end
  endtask

  initial begin
    logic [8:0] rnd;
    int         d1;

    bif.Run = 1'b0;
    bif.DIN = '0;
    @(posedge Clock);
    #1;

    // Reset state: outputs are forced while Resetn is low.
    Resetn = 1'b0;
    cyc(1'b1, 16'h0055, idle_exp(), "rst0");
    cyc(1'b0, 16'h0000, idle_exp(), "rst1");
    Resetn = 1'b1;
    cyc(1'b0, 16'h0123, idle_exp(), "idle");

    // Directed instructions
    run_instr(9'b001_011_000, 16'd5, "mvi_r3");
    run_instr(9'b000_001_110, 16'h1234, "mv_r1_r6");
    run_instr(9'b011_000_111, 16'h0, "sub_r0_r7");
    run_instr(9'b111_010_001, 16'h0, "illegal");
    run_instr(9'b010_010_010, 16'h0, "add_r2_r2");
    run_instr(9'b100_101_011, 16'h0, "and_r5_r3");
    cyc(1'b0, 16'h01ff, idle_exp(), "idle2");

    // Two mvi instructions with Run held high retire 2 cycles apart.
    run_instr(9'b001_000_000, 16'h00aa, "mvi_b2b_a");
    d1 = last_done_cyc;
    run_instr(9'b001_111_000, 16'h00bb, "mvi_b2b_b");
    chk("b2b_gap", 16'(last_done_cyc - d1), 16'd2);
    chk("b2b_gap_seen", 16'(done_gap), 16'd2);

    // Reset while an add is in T2: the instruction is aborted and
    // the FSM restarts in T0.
    cyc(1'b1, 16'h0089, mk(9, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0), "abort_t0");
    cyc(1'b0, 16'h0000, mk(8 - 1, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0), "abort_t1");
    Resetn = 1'b0;
    cyc(1'b1, 16'h0000, idle_exp(), "abort_rst_t2");
    cyc(1'b1, 16'h0000, idle_exp(), "abort_rst2");
    Resetn = 1'b1;
    cyc(1'b0, 16'h0000, idle_exp(), "abort_after");
    run_instr(9'b000_100_010, 16'h0, "post_abort_mv");

    // Random instruction stream with random idle gaps
    for (int n = 0; n < 60; n++) begin
      rnd = 9'($urandom);
      run_instr(rnd, 16'($urandom), "rand");
      if ($urandom_range(0, 3) == 0) begin
        cyc(1'b0, 16'($urandom), idle_exp(), "rand_idle");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
